// File: rtl/grid_vga_renderer.sv
// Renders an 8x8 life grid as a VGA-timed pixel stream (hsync/vsync/de/RGB444).
// Grid updates are double-buffered and swapped only on the first vertical blanking line.
module grid_vga_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL_PX  = 60,
  parameter int X_OFF    = 80
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] grid_in,
  input  logic        grid_valid,
  output logic        grid_ack,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] L_H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] L_V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] L_X_OFF   = 10'(X_OFF);
  localparam logic [9:0] CELL_LAST = 10'(CELL_PX - 1);

  logic [9:0]  r_h_cnt, r_v_cnt;
  logic [9:0]  r_col_px, r_row_px;
  logic [3:0]  r_col_idx, r_row_idx;
  logic [63:0] r_disp_grid, r_pend_grid;
  logic        r_pend_vld;

  logic        w_h_wrap, w_v_wrap, w_active, w_in_grid, w_cell_bit, w_swap_pt;
  logic [9:0]  w_col_px, w_row_px;
  logic [3:0]  w_col_idx, w_row_idx;

  assign w_h_wrap  = (r_h_cnt == H_LAST);
  assign w_v_wrap  = (r_v_cnt == V_LAST);
  // Sub-counters hold the cell position of the current pixel; the restart
  // points are forced here so the first column/row needs no look-ahead.
  assign w_col_px  = (r_h_cnt == L_X_OFF) ? 10'd0 : r_col_px;
  assign w_col_idx = (r_h_cnt == L_X_OFF) ? 4'd0  : r_col_idx;
  assign w_row_px  = (r_v_cnt == 10'd0)   ? 10'd0 : r_row_px;
  assign w_row_idx = (r_v_cnt == 10'd0)   ? 4'd0  : r_row_idx;
  assign w_active  = (r_h_cnt < L_H_ACT) && (r_v_cnt < L_V_ACT);
  assign w_in_grid = !w_col_idx[3] && !w_row_idx[3];
  assign w_cell_bit = r_disp_grid[{w_row_idx[2:0], w_col_idx[2:0]}];
  assign w_swap_pt = (r_h_cnt == 10'd0) && (r_v_cnt == L_V_ACT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // Column index saturates at 8 (outside the grid) until the next X_OFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col_px  <= '0;
      r_col_idx <= 4'd8;
    end else if (w_col_idx != 4'd8) begin
      if (w_col_px == CELL_LAST) begin
        r_col_px  <= '0;
        r_col_idx <= w_col_idx + 4'd1;
      end else begin
        r_col_px  <= w_col_px + 10'd1;
        r_col_idx <= w_col_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row_px  <= '0;
      r_row_idx <= '0;
    end else if (w_h_wrap && (w_row_idx != 4'd8)) begin
      if (w_row_px == CELL_LAST) begin
        r_row_px  <= '0;
        r_row_idx <= w_row_idx + 4'd1;
      end else begin
        r_row_px  <= w_row_px + 10'd1;
        r_row_idx <= w_row_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync                <= 1'b1;
      vsync                <= 1'b1;
      de                   <= 1'b0;
      frame_start          <= 1'b0;
      {red, green, blue}   <= 12'h000;
    end else begin
      hsync       <= !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
      vsync       <= !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
      de          <= w_active;
      frame_start <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
      if (!w_active)
        {red, green, blue} <= 12'h000;
      else if (w_in_grid)
        {red, green, blue} <= w_cell_bit ? 12'hFFF : 12'h000;
      else
        {red, green, blue} <= 12'h003;
    end
  end

  // Handshake: grid_valid is a 1-cycle strobe with no back-pressure (last one
  // before the swap wins); grid_ack pulses once, the cycle after the swap point,
  // whenever a new grid was moved into the display buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp_grid <= '0;
      r_pend_grid <= '0;
      r_pend_vld  <= 1'b0;
      grid_ack    <= 1'b0;
    end else begin
      grid_ack <= w_swap_pt && (grid_valid || r_pend_vld);
      if (w_swap_pt) begin
        if (grid_valid)
          r_disp_grid <= grid_in;
        else if (r_pend_vld)
          r_disp_grid <= r_pend_grid;
        r_pend_vld <= 1'b0;
      end else if (grid_valid) begin
        r_pend_grid <= grid_in;
        r_pend_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_grid_vga_renderer.sv
// Directed bench for grid_vga_renderer using a reduced video timing
// (56x38 total, 48x32 active, 4-pixel cells at x offset 8) to keep frames short.
module tb_grid_vga_renderer;

  localparam int H_ACT = 48, H_FP = 2, H_SY = 4, H_BP = 2;
  localparam int V_ACT = 32, V_FP = 2, V_SY = 2, V_BP = 2;
  localparam int CELL  = 4,  XOFF = 8;
  localparam int HT    = H_ACT + H_FP + H_SY + H_BP;
  localparam int VT    = V_ACT + V_FP + V_SY + V_BP;
  localparam int FR    = HT * VT;
  localparam int SW    = V_ACT * HT;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] grid_in;
  logic        grid_valid;
  logic        grid_ack, frame_start, hsync, vsync, de;
  logic [3:0]  red, green, blue;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          exp_ack_cyc = -1;
  int          last_fs_cyc = -1;
  int          hs_low = 0, vs_low = 0, de_cnt = 0, fs_cnt = 0, ack_cnt = 0;
  logic [63:0] exp_disp = '0;
  logic [63:0] exp_next = '0;

  grid_vga_renderer #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .CELL_PX(CELL), .X_OFF(XOFF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .grid_in(grid_in), .grid_valid(grid_valid),
    .grid_ack(grid_ack), .frame_start(frame_start), .hsync(hsync), .vsync(vsync),
    .de(de), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int h, input int v, input logic [63:0] g);
    int col, row;
    if (!(h < H_ACT && v < V_ACT)) return 12'h000;
    if (h >= XOFF && h < XOFF + 8 * CELL && v < 8 * CELL) begin
      col = (h - XOFF) / CELL;
      row = v / CELL;
      return g[row * 8 + col] ? 12'hFFF : 12'h000;
    end
    return 12'h003;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_de"},    32'(de), 32'd0);
    chk({tag, "_rgb"},   32'({red, green, blue}), 32'd0);
    chk({tag, "_ack"},   32'(grid_ack), 32'd0);
    chk({tag, "_fs"},    32'(frame_start), 32'd0);
  endtask

  // One clock; outputs now show counter position cyc-1 since reset release.
  task automatic tick();
    int p, h, v;
    @(posedge clk);
    #1;
    cyc++;
    p = cyc - 1;
    h = p % HT;
    v = (p / HT) % VT;
    chk("hsync", 32'(hsync), 32'(!(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SY)));
    chk("vsync", 32'(vsync), 32'(!(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SY)));
    chk("de", 32'(de), 32'(h < H_ACT && v < V_ACT));
    chk("rgb", 32'({red, green, blue}), 32'(exp_rgb(h, v, exp_disp)));
    chk("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
    chk("grid_ack", 32'(grid_ack), 32'(cyc == exp_ack_cyc));
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
    if (de) de_cnt++;
    if (grid_ack) ack_cnt++;
    if (frame_start) begin
      if (last_fs_cyc >= 0) chk("fs_period", 32'(cyc - last_fs_cyc), 32'(FR));
      last_fs_cyc = cyc;
      fs_cnt++;
    end
    if (cyc == exp_ack_cyc) exp_disp = exp_next;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Strobe is sampled at counter position == cyc at call time.
  task automatic strobe(input logic [63:0] g);
    grid_in    = g;
    grid_valid = 1'b1;
    tick();
    grid_valid = 1'b0;
    grid_in    = {$urandom, $urandom};
  endtask

  task automatic clear_stats();
    hs_low = 0; vs_low = 0; de_cnt = 0; fs_cnt = 0;
  endtask

  task automatic chk_two_frame_stats(input string tag);
    chk({tag, "_hsync_lows"}, 32'(hs_low), 32'(2 * VT * H_SY));
    chk({tag, "_vsync_lows"}, 32'(vs_low), 32'(2 * V_SY * HT));
    chk({tag, "_de_highs"},   32'(de_cnt), 32'(2 * H_ACT * V_ACT));
    chk({tag, "_frames"},     32'(fs_cnt), 32'd2);
  endtask

  initial begin
    reset_n    = 1'b1;
    grid_valid = 1'b0;
    grid_in    = '0;
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("rst_async");
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("rst_held");
    reset_n = 1'b1;
    cyc = 0;

    // Two empty frames: timing only, blue border around a black grid.
    clear_stats();
    run_to(2 * FR);
    chk_two_frame_stats("t1");

    // Single cell (row 0, col 0) strobed during horizontal blanking of line 5.
    run_to(2 * FR + 5 * HT + 50);
    exp_next = 64'h1;
    exp_ack_cyc = 2 * FR + SW + 1;
    strobe(64'h1);
    run_to(4 * FR);

    // All-ones mid-frame: old image holds to the last active line.
    run_to(4 * FR + 10 * HT);
    exp_next = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_ack_cyc = 4 * FR + SW + 1;
    strobe(64'hFFFF_FFFF_FFFF_FFFF);
    run_to(6 * FR);

    // Two strobes before one swap: the second wins, one ack.
    run_to(6 * FR + 5 * HT + 3);
    strobe(64'h0000_0000_0000_00F0);
    run_to(6 * FR + 20 * HT + 7);
    exp_next = 64'h00FF_0000_0000_0000;
    exp_ack_cyc = 6 * FR + SW + 1;
    strobe(64'h00FF_0000_0000_0000);

    // Strobe exactly in the swap cycle with nothing pending: bypass.
    run_to(7 * FR + SW);
    exp_next = 64'h0102_0408_1020_4080;
    exp_ack_cyc = 7 * FR + SW + 1;
    strobe(64'h0102_0408_1020_4080);
    run_to(8 * FR);

    // Bottom-right cell, strobed just after a swap point: waits a full frame.
    run_to(8 * FR + 33 * HT);
    exp_next = 64'h8000_0000_0000_0000;
    exp_ack_cyc = 9 * FR + SW + 1;
    strobe(64'h8000_0000_0000_0000);
    run_to(11 * FR);
    chk("ack_total", 32'(ack_cnt), 32'd5);

    // Pending grid, then asynchronous reset while a border pixel is shown.
    run_to(11 * FR + 10 * HT);
    exp_ack_cyc = -1;
    strobe(64'h0000_0000_0000_FFFF);
    run_to(11 * FR + 20 * HT + 45);
    chk("pre_rst_de", 32'(de), 32'd1);
    chk("pre_rst_rgb", 32'({red, green, blue}), 32'h003);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("rst_mid_held");
    reset_n = 1'b1;
    cyc = 0;
    last_fs_cyc = -1;
    exp_disp = '0;
    clear_stats();
    run_to(2 * FR);
    chk_two_frame_stats("t6");
    chk("ack_total_end", 32'(ack_cnt), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
